// File: rtl/long_multiplier_pkg.sv
// Shared constants and helpers for the pipelined long multiplier.
// Helpers work at MaxWidth; callers cast to their own DATA_WIDTH.
package long_multiplier_pkg;

   localparam int unsigned DefaultWidth = 32;
   localparam int unsigned MaxWidth     = 64;

   function automatic logic [MaxWidth-1:0] and_row(input logic [MaxWidth-1:0] a,
                                                   input logic                b);
      return a & {MaxWidth{b}};
   endfunction

   function automatic logic [2*MaxWidth-1:0] assemble_product(
      input logic                carry,
      input logic [MaxWidth-1:0] partial,
      input logic [MaxWidth-1:0] low,
      input int unsigned         width
   );
      logic [2*MaxWidth-1:0] p;
      p = (2*MaxWidth)'(low)
        | ((2*MaxWidth)'(partial) << width)
        | ((2*MaxWidth)'(carry) << (2*width - 1));
      return p;
   endfunction

endpackage

// File: rtl/long_multiplier_stage.sv
// One pipeline stage: adds AND-row STAGE_INDEX into the running partial product,
// retires one low product bit and registers the rest.
module long_multiplier_stage
   import long_multiplier_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DefaultWidth,
   parameter int unsigned STAGE_INDEX = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  advance_i,
   input  logic                  valid_i,
   input  logic [DATA_WIDTH-1:0] multiplicand_i,
   // Remaining multiplier bits; bit 0 is the bit consumed by this stage.
   input  logic [DATA_WIDTH-1:0] multiplier_i,
   input  logic [DATA_WIDTH-2:0] partial_i,
   input  logic                  carry_i,
   input  logic [DATA_WIDTH-1:0] low_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] multiplicand_o,
   output logic [DATA_WIDTH-1:0] multiplier_o,
   output logic [DATA_WIDTH-2:0] partial_o,
   output logic                  carry_o,
   output logic [DATA_WIDTH-1:0] low_o
);

   logic [DATA_WIDTH-1:0] row;
   logic [DATA_WIDTH-1:0] sum_lo;
   logic [1:0]            sum_hi;
   logic [DATA_WIDTH-2:0] partial_d;
   logic                  carry_d;
   logic [DATA_WIDTH-1:0] low_d;

   logic                  valid_q;
   logic [DATA_WIDTH-1:0] multiplicand_q;
   logic [DATA_WIDTH-1:0] multiplier_q;
   logic [DATA_WIDTH-2:0] partial_q;
   logic                  carry_q;
   logic [DATA_WIDTH-1:0] low_q;

   always_comb begin
      row    = DATA_WIDTH'(and_row(MaxWidth'(multiplicand_i), multiplier_i[0]));
      sum_lo = {1'b0, row[DATA_WIDTH-2:0]} + {1'b0, partial_i};
      // Top column: previous carry, lower-column carry and the row MSB (max 3).
      sum_hi = {1'b0, carry_i} + {1'b0, sum_lo[DATA_WIDTH-1]} + {1'b0, row[DATA_WIDTH-1]};
      partial_d = {sum_hi[0], sum_lo[DATA_WIDTH-2:1]};
      carry_d   = sum_hi[1];
      low_d     = low_i;
      low_d[STAGE_INDEX] = sum_lo[0];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q        <= 1'b0;
         multiplicand_q <= '0;
         multiplier_q   <= '0;
         partial_q      <= '0;
         carry_q        <= 1'b0;
         low_q          <= '0;
      end else if (advance_i) begin
         valid_q        <= valid_i;
         multiplicand_q <= multiplicand_i;
         multiplier_q   <= multiplier_i >> 1;
         partial_q      <= partial_d;
         carry_q        <= carry_d;
         low_q          <= low_d;
      end
   end

   assign valid_o        = valid_q;
   assign multiplicand_o = multiplicand_q;
   assign multiplier_o   = multiplier_q;
   assign partial_o      = partial_q;
   assign carry_o        = carry_q;
   assign low_o          = low_q;

endmodule

// File: rtl/pipelined_long_multiplier.sv
// Fully pipelined unsigned DATA_WIDTH x DATA_WIDTH multiplier, one multiplier bit per stage,
// with a single global advance shared by every stage.
module pipelined_long_multiplier
   import long_multiplier_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefaultWidth
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [DATA_WIDTH-1:0]   multiplicand_i,
   input  logic [DATA_WIDTH-1:0]   multiplier_i,
   input  logic                    valid_i,
   output logic                    ready_o,
   output logic [2*DATA_WIDTH-1:0] product_o,
   output logic                    valid_o,
   input  logic                    ready_i
);

   logic advance;

   logic                  stage_valid   [DATA_WIDTH];
   logic [DATA_WIDTH-1:0] stage_mcand   [DATA_WIDTH];
   logic [DATA_WIDTH-1:0] stage_mult    [DATA_WIDTH];
   logic [DATA_WIDTH-2:0] stage_partial [DATA_WIDTH];
   logic                  stage_carry   [DATA_WIDTH];
   logic [DATA_WIDTH-1:0] stage_low     [DATA_WIDTH];

   logic [DATA_WIDTH-1:0] row0;
   logic                  s0_valid_q;
   logic [DATA_WIDTH-1:0] s0_mcand_q;
   logic [DATA_WIDTH-1:0] s0_mult_q;
   logic [DATA_WIDTH-2:0] s0_partial_q;
   logic [DATA_WIDTH-1:0] s0_low_q;

   assign advance = ~valid_o | ready_i;
   assign ready_o = advance;
   assign row0    = DATA_WIDTH'(and_row(MaxWidth'(multiplicand_i), multiplier_i[0]));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s0_valid_q   <= 1'b0;
         s0_mcand_q   <= '0;
         s0_mult_q    <= '0;
         s0_partial_q <= '0;
         s0_low_q     <= '0;
      end else if (advance) begin
         s0_valid_q   <= valid_i;
         s0_mcand_q   <= multiplicand_i;
         s0_mult_q    <= multiplier_i >> 1;
         s0_partial_q <= row0[DATA_WIDTH-1:1];
         s0_low_q     <= DATA_WIDTH'(row0[0]);
      end
   end

   assign stage_valid[0]   = s0_valid_q;
   assign stage_mcand[0]   = s0_mcand_q;
   assign stage_mult[0]    = s0_mult_q;
   assign stage_partial[0] = s0_partial_q;
   // A single row cannot produce a carry, so S0's carry is always zero.
   assign stage_carry[0]   = 1'b0;
   assign stage_low[0]     = s0_low_q;

   for (genvar k = 1; k < DATA_WIDTH; k++) begin : gen_stage
      long_multiplier_stage #(
         .DATA_WIDTH (DATA_WIDTH),
         .STAGE_INDEX(k)
      ) u_stage (
         .clk_i         (clk_i),
         .rst_i         (rst_i),
         .advance_i     (advance),
         .valid_i       (stage_valid[k-1]),
         .multiplicand_i(stage_mcand[k-1]),
         .multiplier_i  (stage_mult[k-1]),
         .partial_i     (stage_partial[k-1]),
         .carry_i       (stage_carry[k-1]),
         .low_i         (stage_low[k-1]),
         .valid_o       (stage_valid[k]),
         .multiplicand_o(stage_mcand[k]),
         .multiplier_o  (stage_mult[k]),
         .partial_o     (stage_partial[k]),
         .carry_o       (stage_carry[k]),
         .low_o         (stage_low[k])
      );
   end

   assign valid_o   = stage_valid[DATA_WIDTH-1];
   assign product_o = (2*DATA_WIDTH)'(assemble_product(stage_carry[DATA_WIDTH-1],
                                                       MaxWidth'(stage_partial[DATA_WIDTH-1]),
                                                       MaxWidth'(stage_low[DATA_WIDTH-1]),
                                                       DATA_WIDTH));

   // The last stage's operand copies have no consumer.
   logic unused_last;
   assign unused_last = ^{stage_mcand[DATA_WIDTH-1], stage_mult[DATA_WIDTH-1]};

endmodule

// File: tb/tb_pipelined_long_multiplier.sv
// Bench for pipelined_long_multiplier at DATA_WIDTH=8: directed scenarios plus a
// randomized regression against a queue of A*B results.
module tb_pipelined_long_multiplier;

   localparam int unsigned Dw  = 8;
   localparam int          Lat = Dw - 1;

   logic            clk;
   logic            rst;
   logic [Dw-1:0]   a;
   logic [Dw-1:0]   b;
   logic            vin;
   logic            rdy_o;
   logic [2*Dw-1:0] prod;
   logic            vout;
   logic            rdy_in;

   int n_tests;
   int n_fail;

   pipelined_long_multiplier #(
      .DATA_WIDTH(Dw)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .multiplicand_i(a),
      .multiplier_i  (b),
      .valid_i       (vin),
      .ready_o       (rdy_o),
      .product_o     (prod),
      .valid_o       (vout),
      .ready_i       (rdy_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2*Dw-1:0] model(input logic [Dw-1:0] x, input logic [Dw-1:0] y);
      return (2*Dw)'(x) * (2*Dw)'(y);
   endfunction

   task automatic drive(input logic v, input logic [Dw-1:0] x, input logic [Dw-1:0] y);
      vin = v;
      a   = x;
      b   = y;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int limit, output int edges);
      edges = 0;
      while (!vout && edges < limit) begin
         step();
         edges++;
      end
   endtask

   task automatic test_reset();
      logic [Dw-1:0] x, y;
      int e;
      rst = 1'b0; rdy_in = 1'b1; drive(1'b0, '0, '0);
      #1 rst = 1'b1;
      #1;
      n_tests++;
      if (vout !== 1'b0 || rdy_o !== 1'b1 || prod !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got v=%b r=%b p=%h required v=0 r=1 p=0000", vout, rdy_o, prod);
      end
      step(); step();
      #2 rst = 1'b0;
      x = Dw'($urandom); y = Dw'($urandom);
      drive(1'b1, x, y);
      step();
      drive(1'b0, '0, '0);
      wait_valid(20, e);
      n_tests++;
      if (vout !== 1'b1 || e != Lat || prod !== model(x, y)) begin
         n_fail++;
         $display("FAIL first_accept: got v=%b lat=%0d p=%h required v=1 lat=%0d p=%h",
                  vout, e, prod, Lat, model(x, y));
      end
      step();
   endtask

   task automatic test_single();
      int e;
      drive(1'b1, 8'hFF, 8'hFF);
      step();
      drive(1'b0, '0, '0);
      wait_valid(20, e);
      n_tests++;
      if (vout !== 1'b1 || e != Lat || prod !== 16'hFE01) begin
         n_fail++;
         $display("FAIL single: got v=%b lat=%0d p=%h required v=1 lat=%0d p=fe01",
                  vout, e, prod, Lat);
      end
      step();
      n_tests++;
      if (vout !== 1'b0) begin
         n_fail++;
         $display("FAIL single_one_cycle: got v=%b required v=0", vout);
      end
   endtask

   task automatic test_back_to_back();
      logic [Dw-1:0]   xa [4] = '{8'hA5, 8'h01, 8'h00, 8'h80};
      logic [Dw-1:0]   xb [4] = '{8'h3C, 8'hFF, 8'h7B, 8'h80};
      logic [2*Dw-1:0] ex [4] = '{16'h26AC, 16'h00FF, 16'h0000, 16'h4000};
      logic [2*Dw-1:0] got [8];
      int at [8];
      int n = 0;
      for (int cyc = 0; cyc < 24; cyc++) begin
         if (cyc < 4) drive(1'b1, xa[cyc], xb[cyc]);
         else drive(1'b0, '0, '0);
         step();
         if (vout && n < 8) begin
            got[n] = prod;
            at[n]  = cyc;
            n++;
         end
      end
      n_tests++;
      if (n != 4) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d products required 4", n);
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (got[i] !== ex[i] || at[i] != Lat + i) begin
               n_fail++;
               $display("FAIL b2b_%0d: got p=%h at cycle %0d required p=%h at cycle %0d",
                        i, got[i], at[i], ex[i], Lat + i);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int e;
      int extra = 0;
      rdy_in = 1'b1;
      drive(1'b1, 8'h12, 8'h34);
      step();
      drive(1'b1, 8'h0F, 8'h0F);
      step();
      drive(1'b0, '0, '0);
      wait_valid(20, e);
      n_tests++;
      if (vout !== 1'b1 || e != Lat - 1 || prod !== 16'h03A8) begin
         n_fail++;
         $display("FAIL bp_first: got v=%b lat=%0d p=%h required v=1 lat=%0d p=03a8",
                  vout, e, prod, Lat - 1);
      end
      // An offered pair during the stall must not be taken.
      rdy_in = 1'b0;
      drive(1'b1, 8'h11, 8'h11);
      for (int i = 0; i < 3; i++) begin
         #1;
         n_tests++;
         if (rdy_o !== 1'b0 || vout !== 1'b1 || prod !== 16'h03A8) begin
            n_fail++;
            $display("FAIL bp_stall_%0d: got r=%b v=%b p=%h required r=0 v=1 p=03a8",
                     i, rdy_o, vout, prod);
         end
         step();
      end
      rdy_in = 1'b1;
      drive(1'b0, '0, '0);
      #1;
      n_tests++;
      if (rdy_o !== 1'b1 || vout !== 1'b1 || prod !== 16'h03A8) begin
         n_fail++;
         $display("FAIL bp_release: got r=%b v=%b p=%h required r=1 v=1 p=03a8", rdy_o, vout, prod);
      end
      step();
      n_tests++;
      if (vout !== 1'b1 || prod !== 16'h00E1) begin
         n_fail++;
         $display("FAIL bp_second: got v=%b p=%h required v=1 p=00e1", vout, prod);
      end
      for (int i = 0; i < 12; i++) begin
         step();
         if (vout) extra++;
      end
      n_tests++;
      if (extra != 0) begin
         n_fail++;
         $display("FAIL bp_no_dup: got %0d extra products required 0", extra);
      end
   endtask

   task automatic test_bubbles();
      logic            vb [12];
      logic [2*Dw-1:0] pb [12];
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (cyc == 0) drive(1'b1, 8'h55, 8'h03);
         else if (cyc == 2) drive(1'b1, 8'hAA, 8'h02);
         else drive(1'b0, 8'hEE, 8'hEE);
         step();
         vb[cyc] = vout;
         pb[cyc] = prod;
      end
      n_tests++;
      if (vb[Lat-1] !== 1'b0 || vb[Lat] !== 1'b1 || vb[Lat+1] !== 1'b0 || vb[Lat+2] !== 1'b1
          || vb[Lat+3] !== 1'b0) begin
         n_fail++;
         $display("FAIL bubble_pattern: got %b%b%b%b%b required 01010",
                  vb[Lat-1], vb[Lat], vb[Lat+1], vb[Lat+2], vb[Lat+3]);
      end
      n_tests++;
      if (pb[Lat] !== 16'h00FF || pb[Lat+2] !== 16'h0154) begin
         n_fail++;
         $display("FAIL bubble_products: got %h,%h required 00ff,0154", pb[Lat], pb[Lat+2]);
      end
   endtask

   task automatic test_reset_midflight();
      int e;
      int stale = 0;
      rdy_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, Dw'($urandom), Dw'($urandom));
         step();
      end
      drive(1'b0, '0, '0);
      wait_valid(20, e);
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (vout !== 1'b0 || rdy_o !== 1'b1 || prod !== '0) begin
         n_fail++;
         $display("FAIL midflight_reset: got v=%b r=%b p=%h required v=0 r=1 p=0000",
                  vout, rdy_o, prod);
      end
      step();
      #2 rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (vout) stale++;
      end
      n_tests++;
      if (stale != 0) begin
         n_fail++;
         $display("FAIL midflight_stale: got %0d products required 0", stale);
      end
      drive(1'b1, 8'h07, 8'h09);
      step();
      drive(1'b0, '0, '0);
      wait_valid(20, e);
      n_tests++;
      if (vout !== 1'b1 || e != Lat || prod !== 16'h003F) begin
         n_fail++;
         $display("FAIL midflight_new: got v=%b lat=%0d p=%h required v=1 lat=%0d p=003f",
                  vout, e, prod, Lat);
      end
      step();
   endtask

   task automatic test_random();
      logic [2*Dw-1:0] q [$];
      logic [2*Dw-1:0] ex;
      logic [2*Dw-1:0] held_p;
      logic            held = 1'b0;
      int accepted = 0;
      int cycles   = 0;
      while (accepted < 10000 && cycles < 80000) begin
         if (held) begin
            n_tests++;
            if (vout !== 1'b1 || prod !== held_p) begin
               n_fail++;
               $display("FAIL rand_stall_hold: got v=%b p=%h required v=1 p=%h", vout, prod, held_p);
            end
         end
         vin    = ($urandom_range(3) != 0);
         a      = Dw'($urandom);
         b      = Dw'($urandom);
         rdy_in = ($urandom_range(3) != 0);
         #1;
         held   = vout && !rdy_in;
         held_p = prod;
         if (vout && rdy_in) begin
            n_tests++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL rand_unexpected: got p=%h required no product", prod);
            end else begin
               ex = q.pop_front();
               if (prod !== ex) begin
                  n_fail++;
                  $display("FAIL rand_product: got %h required %h", prod, ex);
               end
            end
         end
         if (vin && rdy_o) begin
            q.push_back(model(a, b));
            accepted++;
         end
         @(posedge clk);
         #1;
         cycles++;
      end
      n_tests++;
      if (accepted < 10000) begin
         n_fail++;
         $display("FAIL rand_budget: got %0d accepted required 10000", accepted);
      end
      drive(1'b0, '0, '0);
      rdy_in = 1'b1;
      for (int i = 0; i < 30; i++) begin
         #1;
         if (vout) begin
            n_tests++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL drain_unexpected: got p=%h required no product", prod);
            end else begin
               ex = q.pop_front();
               if (prod !== ex) begin
                  n_fail++;
                  $display("FAIL drain_product: got %h required %h", prod, ex);
               end
            end
         end
         @(posedge clk);
         #1;
      end
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_empty: got %0d outstanding required 0", q.size());
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_bubbles();
      test_reset_midflight();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipelined_long_multiplier.md
Name: pipelined_long_multiplier

Overview:
- Fully pipelined unsigned DATA_WIDTH x DATA_WIDTH long multiplier with valid/ready handshakes on both sides.
- Each pipeline stage consumes one multiplier bit and sums one AND-product row into the running partial product.
- Each stage retires one final product bit and registers the remaining partial product and carry.
- Accepts one operand pair per cycle; produces a 2*DATA_WIDTH product.

Parameters:
- DATA_WIDTH, 32, operand width in bits. Must be a power of 2 and >= 4.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, asynchronous, active-high
- multiplicand_i  in  DATA_WIDTH  operand A, unsigned
- multiplier_i  in  DATA_WIDTH  operand B, unsigned
- valid_i  in  1  operand pair valid
- ready_o  out  1  pipeline can accept this cycle
- product_o  out  2*DATA_WIDTH  A*B
- valid_o  out  1  product_o valid
- ready_i  in  1  consumer accepts product_o

Behaviour:
- Stages: S0..S(DATA_WIDTH-1), one register bank per stage. Each bank holds:
  - valid bit
  - multiplicand (DATA_WIDTH)
  - unused multiplier bits
  - partial product (DATA_WIDTH-1)
  - carry (1)
  - retired low product bits (k+1 in stage k)
- S0 load: and_row = A & {DATA_WIDTH{B[0]}}.
  - low bit[0] <= and_row[0]
  - partial <= and_row[DATA_WIDTH-1:1]
  - carry <= 0
- Stage k>=1, row k = A & {DATA_WIDTH{B[k]}}:
  - {c, r[DATA_WIDTH-3:0], pbit} = row[DATA_WIDTH-2:0] + partial
  - {carry_next, r[DATA_WIDTH-2]} = prev_carry + c + row[DATA_WIDTH-1]
  - low bit[k] <= pbit
  - partial <= r
  - carry <= carry_next
- Output: product_o = {carry, partial, low[DATA_WIDTH-1:0]} of the last stage.
- Width rule: no overflow is possible; the product is exact modulo nothing.
- Advance: advance = ~valid_o | ready_i.
  - All stages shift together when advance=1.
  - All stages hold when advance=0.
  - ready_o = advance (combinational).
- Accept: a pair is accepted when valid_i & ready_o.
  - S0.valid <= valid_i on advance.
  - A bubble enters when valid_i=0; bubbles are not compressed.
- Latency:
  - Product appears on the DATA_WIDTH-1th advancing edge after the acceptance edge.
  - Throughput is 1 per cycle while ready_i=1.
- Stall: while valid_o & ~ready_i, product_o and valid_o stay stable. All internal stages freeze.
- Simultaneous accept and stall: impossible by construction, since ready_o=0.
- Data registers of invalid stages are don't-care. product_o must be ignored when valid_o=0.
- Reset (async, any time, including mid-operation):
  - all valid bits <= 0; in-flight operations are discarded
  - valid_o=0, product_o=0
  - ready_o=1 immediately after assertion
  - data registers reset to 0
- Reset release: the first acceptance is possible on the first edge after deassertion.

Decomposition:
- Package long_multiplier_pkg holds:
  - default width constant
  - function assembling the final product from carry/partial/low bits
  - function computing an AND row
- Sub-module long_multiplier_stage:
  - one row adder plus its register bank
  - parameterized by DATA_WIDTH and STAGE_INDEX
  - advance as enable
  - generate-instantiated for stages 1..DATA_WIDTH-1
- S0 is inline in the top.

Test Plan (DATA_WIDTH=8, latency 8 cycles including the accept cycle):
- Single op, ready_i=1: A=0xFF, B=0xFF -> after 7 further edges, valid_o=1 for one cycle, product_o=0xFE01.
- Back-to-back ops, ready_i=1:
  - stimulus: (0xA5,0x3C), (0x01,0xFF), (0x00,0x7B), (0x80,0x80) in consecutive cycles
  - response: products 0x26AC, 0x00FF, 0x0000, 0x4000 on consecutive cycles, in order
- Backpressure:
  - stimulus: drive ready_i=0 when the first of two pipelined ops (0x12*0x34, 0x0F*0x0F) reaches the output; hold 3 cycles
  - response: ready_o=0, product_o stays 0x03A8; after release, 0x03A8 then 0x00E1 with no loss or duplication
- Bubbles: valid_i alternates 1/0 with (0x55,0x03), (0xAA,0x02) -> valid_o pattern 1,0,1; products 0x00FF, 0x0154.
- Reset mid-flight:
  - stimulus: rst_i asserted asynchronously between edges while 4 ops are in flight
  - response: valid_o drops immediately, ready_o=1; no stale product appears after release; a new 0x07*0x09 returns 0x003F
- Random regression: 10k random pairs with random ready_i and valid_i, checked against a scoreboard model of A*B.
